pixel_stream_tx: RTL and testbench

Streaming transmitter for the pixel byte interface consumed by the bounding-box unit. Reads a stored image byte-by-byte from a synchronous memory read port (R, G, B per pixel, raster order). Emits one frame-reset token, then every byte as a {value, index} word with a valid/ready handshake. Sits between the image buffer RAM/ROM and the box-detection block.

---
 rtl/pixel_stream_pkg.sv | 18 +
 rtl/stream_skid_buf.sv | 52 +++++
 rtl/pixel_stream_tx.sv | 113 +++++++++++
 tb/tb_pixel_stream_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_stream_pkg.sv
// Shared types and constants for the pixel byte streaming transmitter.
// Output words carry the byte value in [31:24] and its index in [23:0].
package pixel_stream_pkg;

  typedef enum logic [1:0] {IDLE, TOKEN, STREAM, DONE} state_t;

  localparam int VALUE_MSB = 31;
  localparam int VALUE_LSB = 24;
  localparam int INDEX_MSB = 23;

  localparam logic [7:0] WHITE = 8'hFF;

  // The frame-reset word: a white value tagged with the consumer's reset index.
  function automatic logic [31:0] token_word(input logic [31:0] token_idx);
    token_word = {WHITE, token_idx[INDEX_MSB:0]};
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry buffer (output register plus one skid entry) for 32-bit stream words.
// count reports occupancy so the upstream reader can run on credit.
module stream_skid_buf #(
  parameter int W = 32
) (
  input  logic         CLOCK_50,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   count
);

  // Handshake: a word moves across a port when valid && ready are both high at
  // a rising edge; valid never depends on ready, and a presented word holds
  // stable until it moves.
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         push;
  logic         pop;

  assign in_ready = !skid_valid || out_ready;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign count    = {1'b0, out_valid} + {1'b0, skid_valid};

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || pop) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= push;
        if (push) skid_data <= in_data;
      end else begin
        out_valid <= push;
        if (push) out_data <= in_data;
      end
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/pixel_stream_tx.sv
// Streams a stored image byte-by-byte as {value, index} words, preceded by one
// frame-reset token, reading from a synchronous memory port on credit.
module pixel_stream_tx
  import pixel_stream_pkg::*;
#(
  parameter int WIDTH       = 100,
  parameter int HEIGHT      = 100,
  parameter int RESET_TOKEN = 99999,
  parameter int ADDR_W      = 15
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic              wr_en,
  input  logic              sink_ready,
  output logic [31:0]       hex_value_index,
  output logic [1:0]        fsm_state
);

  localparam int N = 3 * WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [INDEX_MSB:0] LAST_IDX = 24'(N - 1);

  if (N - 1 >= RESET_TOKEN) begin : g_bad_token
    $error("pixel_stream_tx: byte indices would reach RESET_TOKEN");
  end
  if (ADDR_W > 24 || (longint'(1) << ADDR_W) < longint'(N)) begin : g_bad_addr_w
    $error("pixel_stream_tx: ADDR_W cannot address the frame or exceeds the index field");
  end

  state_t            state;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_done;
  logic              rd_pend;
  logic [ADDR_W-1:0] rd_pend_addr;
  logic              issue;
  logic              xfer;
  logic [2:0]        credit_sum;
  logic              buf_in_ready;
  logic              buf_valid;
  logic [31:0]       buf_data;
  logic [1:0]        buf_count;

  stream_skid_buf #(.W(32)) u_buf (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .in_valid  (rd_pend),
    .in_data   ({mem_rdata, 24'(rd_pend_addr)}),
    .in_ready  (buf_in_ready),
    .out_valid (buf_valid),
    .out_data  (buf_data),
    .out_ready (state == STREAM && sink_ready),
    .count     (buf_count)
  );

  assign xfer       = buf_valid && state == STREAM && sink_ready;
  assign credit_sum = {1'b0, buf_count} + {2'b00, rd_pend} - {2'b00, xfer};

  // Address 0 is requested in the start-accept cycle so byte 0 is already in
  // the buffer when the token is taken; buf_in_ready is implied by the credit.
  assign issue = reset_n &&
                 ((state == IDLE && start) ||
                  ((state == TOKEN || state == STREAM) && !rd_done &&
                   buf_in_ready && credit_sum < 3'd2));

  assign mem_rd_en = issue;
  assign mem_addr  = rd_addr;

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state        <= IDLE;
      rd_addr      <= '0;
      rd_done      <= 1'b0;
      rd_pend      <= 1'b0;
      rd_pend_addr <= '0;
    end else begin
      rd_pend <= issue;
      if (issue) begin
        rd_pend_addr <= rd_addr;
        if (rd_addr == LAST_ADDR) rd_done <= 1'b1;
        else rd_addr <= rd_addr + 1'b1;
      end
      case (state)
        IDLE:    if (start) state <= TOKEN;
        TOKEN:   if (sink_ready) state <= STREAM;
        STREAM:  if (xfer && buf_data[INDEX_MSB:0] == LAST_IDX) state <= DONE;
        DONE: begin
          state   <= IDLE;
          rd_addr <= '0;
          rd_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == TOKEN) || (state == STREAM);
  assign done      = (state == DONE);
  assign wr_en     = (state == TOKEN) || (state == STREAM && buf_valid);
  assign fsm_state = state;

  always_comb begin
    hex_value_index = '0;
    if (state == TOKEN) hex_value_index = token_word(32'(RESET_TOKEN));
    else if (state == STREAM && buf_valid) hex_value_index = buf_data;
  end

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Bench for pixel_stream_tx on a 4x2 image: a frame model fills an expected
// queue, a negedge monitor pops it on every transfer; directed timing checks.
module tb_pixel_stream_tx;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 2;
  localparam int TOKEN_IDX = 99999;
  localparam int ADDR_W = 5;
  localparam int N = 3 * WIDTH * HEIGHT;
  localparam int BOUND = 300;
  localparam logic [31:0] TOKEN_W = 32'hFF01869F;

  logic              CLOCK_50 = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_rdata = 8'h00;
  logic              wr_en;
  logic              sink_ready = 1'b1;
  logic [31:0]       hex_value_index;
  logic [1:0]        fsm_state;

  logic [7:0]  mem [0:(1<<ADDR_W)-1];
  logic [31:0] exp_q [$];
  int          n_checks = 0;
  int          n_errors = 0;

  logic [31:0] rec_hex [0:BOUND];
  logic        rec_wr  [0:BOUND];
  logic        rec_busy[0:BOUND];
  logic        rec_done[0:BOUND];
  logic        rec_rd  [0:BOUND];

  pixel_stream_tx #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .RESET_TOKEN(TOKEN_IDX), .ADDR_W(ADDR_W)
  ) dut (
    .CLOCK_50        (CLOCK_50),
    .reset_n         (reset_n),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .mem_addr        (mem_addr),
    .mem_rd_en       (mem_rd_en),
    .mem_rdata       (mem_rdata),
    .wr_en           (wr_en),
    .sink_ready      (sink_ready),
    .hex_value_index (hex_value_index),
    .fsm_state       (fsm_state)
  );

  // clock / reset block
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // synchronous-read memory model: data valid the cycle after the strobe
  always @(posedge CLOCK_50) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: one token, then byte k from address k tagged with index k
  task automatic push_frame();
    exp_q.push_back(TOKEN_W);
    for (int k = 0; k < N; k++) exp_q.push_back({mem[k], 24'(k)});
  endtask

  // scoreboard monitor
  logic        prev_stall = 1'b0;
  logic [31:0] prev_word = '0;
  logic        exp_done = 1'b0;

  always @(negedge CLOCK_50) begin
    logic [31:0] w;
    if (!reset_n) begin
      prev_stall = 1'b0;
      exp_done   = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", {31'd0, wr_en, hex_value_index}, {31'd0, 1'b1, prev_word});
      check("done_pulse", {63'd0, done}, {63'd0, exp_done});
      exp_done = 1'b0;
      if (!wr_en) check("idle_word_zero", {32'd0, hex_value_index}, 64'd0);
      if (wr_en && sink_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {32'd0, hex_value_index}, 64'hDEAD_0000_0000_0000);
        end else begin
          w = exp_q.pop_front();
          check("word", {32'd0, hex_value_index}, {32'd0, w});
          if (w != TOKEN_W && w[23:0] == 24'(N - 1)) exp_done = 1'b1;
        end
      end
      prev_stall = wr_en && !sink_ready;
      prev_word  = hex_value_index;
    end
  end

  // driver tasks
  task automatic wait_cycle();
    @(posedge CLOCK_50);
    #1;
  endtask

  // modes: 0 ready, 1 stall cycles 4-6, 2 stall cycles 1-3, 3 random, 4 stray start in cycle 5
  task automatic run_frame(input int mode, input int abort_cyc, input bit hold, output int done_cyc);
    wait_cycle();
    start = 1'b1;
    push_frame();
    done_cyc = 0;
    for (int c = 1; c <= BOUND; c++) begin
      wait_cycle();
      if (!hold) start = (mode == 3) ? ($urandom_range(0, 7) == 0) : (mode == 4 && c == 5);
      case (mode)
        1:       sink_ready = !(c >= 4 && c <= 6);
        2:       sink_ready = (c > 3);
        3:       sink_ready = ($urandom_range(0, 3) != 0);
        default: sink_ready = 1'b1;
      endcase
      if (c == abort_cyc) reset_n = 1'b0;
      #1;
      rec_hex[c]  = hex_value_index;
      rec_wr[c]   = wr_en;
      rec_busy[c] = busy;
      rec_done[c] = done;
      rec_rd[c]   = mem_rd_en;
      if (c == abort_cyc) break;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    if (!hold) start = 1'b0;
    sink_ready = 1'b1;
    if (abort_cyc == 0) check("frame_done_seen", {63'd0, done_cyc != 0}, 64'd1);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int c = 1; c <= BOUND; c++) begin
      wait_cycle();
      #1;
      if (done) begin
        cyc = c;
        break;
      end
    end
    check("second_done_seen", {63'd0, cyc != 0}, 64'd1);
  endtask

  initial begin
    int d;
    for (int k = 0; k < (1 << ADDR_W); k++) mem[k] = 8'(k);

    repeat (3) wait_cycle();
    reset_n = 1'b1;
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_wr_en", {63'd0, wr_en}, 64'd0);
    check("rst_mem_rd_en", {63'd0, mem_rd_en}, 64'd0);
    check("rst_mem_addr", {59'd0, mem_addr}, 64'd0);
    check("rst_word", {32'd0, hex_value_index}, 64'd0);
    check("rst_fsm_idle", {62'd0, fsm_state}, 64'd0);

    // full-rate frame, cycle-exact timing
    run_frame(0, 0, 0, d);
    check("t1_done_cycle", 64'(d), 64'(N + 2));
    for (int c = 1; c <= N + 2; c++) begin
      check("t1_busy", {63'd0, rec_busy[c]}, {63'd0, c <= N + 1});
      check("t1_wr_en", {63'd0, rec_wr[c]}, {63'd0, c <= N + 1});
      if (c == 1) check("t1_token", {32'd0, rec_hex[c]}, {32'd0, TOKEN_W});
      else if (c <= N + 1) check("t1_byte", {32'd0, rec_hex[c]}, {32'd0, 8'(c - 2), 24'(c - 2)});
    end
    check("t1_queue_drained", 64'(exp_q.size()), 64'd0);

    // downstream stall in cycles 4-6
    run_frame(1, 0, 0, d);
    for (int c = 4; c <= 7; c++) check("t2_held_byte2", {32'd0, rec_hex[c]}, {32'd0, 8'd2, 24'd2});
    for (int c = 4; c <= 6; c++) check("t2_no_read_when_full", {63'd0, rec_rd[c]}, 64'd0);
    check("t2_byte3", {32'd0, rec_hex[8]}, {32'd0, 8'd3, 24'd3});
    check("t2_done_cycle", 64'(d), 64'(N + 5));
    check("t2_queue_drained", 64'(exp_q.size()), 64'd0);

    // token stalled for the first three cycles
    run_frame(2, 0, 0, d);
    check("t3_token_held", {32'd0, rec_hex[3]}, {32'd0, TOKEN_W});
    check("t3_token_taken", {32'd0, rec_hex[4]}, {32'd0, TOKEN_W});
    check("t3_byte0", {32'd0, rec_hex[5]}, {32'd0, 8'd0, 24'd0});
    check("t3_done_cycle", 64'(d), 64'(N + 5));

    // reset while byte 10 is presented, then a clean restart
    run_frame(0, 12, 0, d);
    check("t4_byte10", {32'd0, rec_hex[12]}, {32'd0, 8'd10, 24'd10});
    exp_q.delete();
    wait_cycle();
    reset_n = 1'b1;
    #1;
    check("t4_wr_en_cleared", {63'd0, wr_en}, 64'd0);
    check("t4_busy_cleared", {63'd0, busy}, 64'd0);
    check("t4_rd_en_cleared", {63'd0, mem_rd_en}, 64'd0);
    run_frame(0, 0, 0, d);
    check("t4_restart_token", {32'd0, rec_hex[1]}, {32'd0, TOKEN_W});
    check("t4_restart_byte0", {32'd0, rec_hex[2]}, {32'd0, 8'd0, 24'd0});
    check("t4_done_cycle", 64'(d), 64'(N + 2));

    // stray start mid-frame is ignored
    run_frame(4, 0, 0, d);
    check("t5_done_cycle", 64'(d), 64'(N + 2));
    check("t5_queue_drained", 64'(exp_q.size()), 64'd0);

    // start held high: next token two cycles after done
    run_frame(0, 0, 1, d);
    check("t5b_done_cycle", 64'(d), 64'(N + 2));
    wait_cycle();
    #1;
    check("t5b_idle_gap", {63'd0, wr_en}, 64'd0);
    push_frame();
    wait_cycle();
    start = 1'b0;
    #1;
    check("t5b_token_again", {31'd0, wr_en, hex_value_index}, {31'd0, 1'b1, TOKEN_W});
    wait_done(d);
    check("t5b_queue_drained", 64'(exp_q.size()), 64'd0);

    // random image contents, random back-pressure and random start pulses
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < N; k++) mem[k] = 8'($urandom_range(0, 255));
      run_frame(3, 0, 0, d);
      check("rand_queue_drained", 64'(exp_q.size()), 64'd0);
    end

    repeat (3) wait_cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
